// File: rtl/uart_time_pkg.sv
// Shared constants, state encodings and helpers for the UART time responder.
package uart_time_pkg;

  localparam logic [4:0] FRAME_LEN  = 5'd21;

  localparam logic [7:0] CHAR_ZERO  = 8'h30;
  localparam logic [7:0] CHAR_QMARK = 8'h3F;
  localparam logic [7:0] CHAR_DASH  = 8'h2D;
  localparam logic [7:0] CHAR_COLON = 8'h3A;
  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_LF    = 8'h0A;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_START = 2'd1,
    R_DATA  = 2'd2,
    R_STOP  = 2'd3
  } rx_state_e;

  typedef enum logic [1:0] {
    T_IDLE  = 2'd0,
    T_START = 2'd1,
    T_DATA  = 2'd2,
    T_STOP  = 2'd3
  } tx_state_e;

  // One coherent copy of the clock core's BCD outputs.
  typedef struct packed {
    logic [15:0] year;
    logic [7:0]  month;
    logic [7:0]  day;
    logic [7:0]  hour;
    logic [7:0]  minute;
    logic [7:0]  second;
  } time_snap_t;

  // Digit nibble to ASCII; non-decimal nibbles become '?'.
  function automatic logic [7:0] bcd_to_ascii(input logic [3:0] nib);
    logic [7:0] c;
    if (nib <= 4'd9) begin
      c = CHAR_ZERO + {4'h0, nib};
    end else begin
      c = CHAR_QMARK;
    end
    return c;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter. ready_o is high when a load is taken this cycle,
// including the last cycle of a stop bit so bytes chain with no idle gap.
module uart_tx_byte
  import uart_time_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       tx_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             bit_end_s;

  assign bit_end_s = (cnt_q == BIT_LAST);
  assign ready_o   = (state_q == T_IDLE) || ((state_q == T_STOP) && bit_end_s);
  assign tx_o      = tx_q;

  // Bit sequencer: start, eight data bits LSB first, stop; optional chained reload.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    case (state_q)
      T_IDLE: begin
        if (load_i) begin
          state_d = T_START;
          shift_d = data_i;
          cnt_d   = CNT_ZERO;
          tx_d    = 1'b0;
        end else begin
          tx_d    = 1'b1;
        end
      end
      T_START: begin
        if (bit_end_s) begin
          state_d = T_DATA;
          cnt_d   = CNT_ZERO;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      T_DATA: begin
        if (bit_end_s) begin
          cnt_d = CNT_ZERO;
          if (bit_q == 3'd7) begin
            state_d = T_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      T_STOP: begin
        if (bit_end_s) begin
          cnt_d = CNT_ZERO;
          if (load_i) begin
            state_d = T_START;
            shift_d = data_i;
            tx_d    = 1'b0;
          end else begin
            state_d = T_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = T_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Transmitter state register; line idles high out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= T_IDLE;
      cnt_q   <= CNT_ZERO;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/uart_time_responder.sv
// UART time responder: on a request byte, snapshots the BCD date/time and
// replies with "YYYY-MM-DD HH:MM:SS\r\n".
module uart_time_responder
  import uart_time_pkg::*;
#(
  parameter int         CLK_FREQ = 100_000_000,
  parameter int         BAUD     = 115200,
  parameter logic [7:0] REQ_BYTE = 8'h54
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx_pin,
  output logic        tx_pin,
  input  logic [15:0] year_bcd,
  input  logic [7:0]  month_bcd,
  input  logic [7:0]  day_bcd,
  input  logic [7:0]  hour_bcd,
  input  logic [7:0]  minute_bcd,
  input  logic [7:0]  second_bcd,
  output logic        busy,
  output logic        done,
  output logic        frame_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             rx_valid_q, rx_valid_d;
  logic             ferr_q, ferr_d;
  time_snap_t       snap_q, snap_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [4:0]       idx_q, idx_d;
  logic             accept_s, load_s, tx_ready_s;
  logic [7:0]       tx_byte_s;

  assign busy      = busy_q;
  assign done      = done_q;
  assign frame_err = ferr_q;

  // Two-flop synchroniser plus a delayed copy for start-edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_pin;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Receiver: mid-bit sampling, glitch rejection on start, stop-bit validation.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = 1'b0;
    ferr_d     = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = R_START;
          rx_cnt_d   = CNT_ZERO;
        end else begin
          rx_state_d = R_IDLE;
        end
      end
      R_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = CNT_ZERO;
          rx_bit_d = 3'd0;
          if (!rx_sync_q) begin
            rx_state_d = R_DATA;
          end else begin
            rx_state_d = R_IDLE;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      R_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = CNT_ZERO;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = R_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      R_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = CNT_ZERO;
          rx_state_d = R_IDLE;
          if (rx_sync_q) begin
            rx_valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  // Receiver state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state_q <= R_IDLE;
      rx_cnt_q   <= CNT_ZERO;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_valid_q <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_valid_q <= rx_valid_d;
      ferr_q     <= ferr_d;
    end
  end

  // The done cycle still counts as busy, so a request landing on it is dropped.
  assign accept_s = rx_valid_q && (rx_shift_q == REQ_BYTE) && !busy_q && !done_q;

  // Frame sequencing: snapshot, feed bytes to the transmitter, finish with done.
  always_comb begin
    snap_d = snap_q;
    busy_d = busy_q;
    done_d = 1'b0;
    idx_d  = idx_q;
    load_s = 1'b0;
    if (accept_s) begin
      snap_d = {year_bcd, month_bcd, day_bcd, hour_bcd, minute_bcd, second_bcd};
      busy_d = 1'b1;
      idx_d  = 5'd0;
    end else if (busy_q) begin
      if (idx_q != FRAME_LEN) begin
        load_s = 1'b1;
        if (tx_ready_s) begin
          idx_d = idx_q + 5'd1;
        end else begin
          idx_d = idx_q;
        end
      end else if (tx_ready_s) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        busy_d = 1'b1;
      end
    end else begin
      load_s = 1'b0;
    end
  end

  // Frame control registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_q <= '{default: '0};
      busy_q <= 1'b0;
      done_q <= 1'b0;
      idx_q  <= 5'd0;
    end else begin
      snap_q <= snap_d;
      busy_q <= busy_d;
      done_q <= done_d;
      idx_q  <= idx_d;
    end
  end

  // Byte mux: frame position to ASCII character.
  always_comb begin
    tx_byte_s = CHAR_SPACE;
    case (idx_q)
      5'd0:  tx_byte_s = bcd_to_ascii(snap_q.year[15:12]);
      5'd1:  tx_byte_s = bcd_to_ascii(snap_q.year[11:8]);
      5'd2:  tx_byte_s = bcd_to_ascii(snap_q.year[7:4]);
      5'd3:  tx_byte_s = bcd_to_ascii(snap_q.year[3:0]);
      5'd4:  tx_byte_s = CHAR_DASH;
      5'd5:  tx_byte_s = bcd_to_ascii(snap_q.month[7:4]);
      5'd6:  tx_byte_s = bcd_to_ascii(snap_q.month[3:0]);
      5'd7:  tx_byte_s = CHAR_DASH;
      5'd8:  tx_byte_s = bcd_to_ascii(snap_q.day[7:4]);
      5'd9:  tx_byte_s = bcd_to_ascii(snap_q.day[3:0]);
      5'd10: tx_byte_s = CHAR_SPACE;
      5'd11: tx_byte_s = bcd_to_ascii(snap_q.hour[7:4]);
      5'd12: tx_byte_s = bcd_to_ascii(snap_q.hour[3:0]);
      5'd13: tx_byte_s = CHAR_COLON;
      5'd14: tx_byte_s = bcd_to_ascii(snap_q.minute[7:4]);
      5'd15: tx_byte_s = bcd_to_ascii(snap_q.minute[3:0]);
      5'd16: tx_byte_s = CHAR_COLON;
      5'd17: tx_byte_s = bcd_to_ascii(snap_q.second[7:4]);
      5'd18: tx_byte_s = bcd_to_ascii(snap_q.second[3:0]);
      5'd19: tx_byte_s = CHAR_CR;
      5'd20: tx_byte_s = CHAR_LF;
      default: tx_byte_s = CHAR_SPACE;
    endcase
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk    (clk),
    .reset_n(reset_n),
    .load_i (load_s),
    .data_i (tx_byte_s),
    .ready_o(tx_ready_s),
    .tx_o   (tx_pin)
  );

endmodule
